z80_bus_loader: RTL

Bus-master loader that shares the Z80 (tv80s) memory bus with the CPU through the BUSRQ/BUSAK handshake. On a start pulse it requests the bus, waits for the CPU to float it, writes a byte stream into memory from a base address, then releases the bus. It is used to preload programs and operands and to patch memory between CPU runs without poking the memory array hierarchically.

---
 rtl/z80_bus_loader_if.sv | 31 +++
 rtl/z80_bus_loader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/z80_bus_loader_if.sv
// z80_bus_loader_if: control, byte-stream and Z80 memory-bus signals of the bus-master loader.
//   master modport: loader side (drives s_ready, bus request, memory strobes and status).
//   slave modport : environment side (drives start/base_addr/length, stream bytes, busak_n).
interface z80_bus_loader_if;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] length;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        busrq_n;
    logic        busak_n;
    logic        bus_own;
    logic [15:0] mem_a;
    logic [7:0]  mem_do;
    logic        mem_mreq_n;
    logic        mem_wr_n;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  start, base_addr, length, s_valid, s_data, busak_n,
        output s_ready, busrq_n, bus_own, mem_a, mem_do, mem_mreq_n, mem_wr_n, busy, done, err
    );

    modport slave (
        output start, base_addr, length, s_valid, s_data, busak_n,
        input  s_ready, busrq_n, bus_own, mem_a, mem_do, mem_mreq_n, mem_wr_n, busy, done, err
    );
endinterface

// File: rtl/z80_bus_loader.sv
// z80_bus_loader: takes the Z80 bus via BUSRQ/BUSAK and writes a byte stream to memory from a base address.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : z80_bus_loader_if.master (start/base_addr/length control, s_valid/s_data/s_ready stream,
//                busrq_n/busak_n handshake, bus_own/mem_a/mem_do/mem_mreq_n/mem_wr_n bus, busy/done/err status)
module z80_bus_loader #(
    parameter int ACK_TIMEOUT = 1024,
    parameter int CNT_W       = 11
) (
    input  logic              clk,
    input  logic              reset,
    z80_bus_loader_if.master  bus
);
    typedef enum logic [2:0] {IDLE, REQ, LOAD, STROBE, REL} state_t;

    state_t           state_q, state_d;
    logic [15:0]      addr_q, addr_d;
    logic [15:0]      rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busrq_n_q, busrq_n_d;
    logic             bus_own_q, bus_own_d;
    logic             s_ready_q, s_ready_d;
    logic [15:0]      mem_a_q, mem_a_d;
    logic [7:0]       mem_do_q, mem_do_d;
    logic             mem_mreq_n_q, mem_mreq_n_d;
    logic             mem_wr_n_q, mem_wr_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             lost;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            cnt_q        <= '0;
            busrq_n_q    <= 1'b1;
            bus_own_q    <= 1'b0;
            s_ready_q    <= 1'b0;
            mem_a_q      <= '0;
            mem_do_q     <= '0;
            mem_mreq_n_q <= 1'b1;
            mem_wr_n_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            cnt_q        <= cnt_d;
            busrq_n_q    <= busrq_n_d;
            bus_own_q    <= bus_own_d;
            s_ready_q    <= s_ready_d;
            mem_a_q      <= mem_a_d;
            mem_do_q     <= mem_do_d;
            mem_mreq_n_q <= mem_mreq_n_d;
            mem_wr_n_q   <= mem_wr_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // The CPU floating busak_n back high while we think we own the bus is a lost grant.
    assign lost = ((state_q == LOAD) || (state_q == STROBE)) && bus.busak_n;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        cnt_d        = cnt_q;
        busrq_n_d    = busrq_n_q;
        bus_own_d    = bus_own_q;
        s_ready_d    = s_ready_q;
        mem_a_d      = mem_a_q;
        mem_do_d     = mem_do_q;
        mem_mreq_n_d = mem_mreq_n_q;
        mem_wr_n_d   = mem_wr_n_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d = bus.base_addr;
                    rem_d  = bus.length;
                    if (bus.length == 16'd0) begin
                        // Nothing to move: finish immediately without touching the bus.
                        done_d = 1'b1;
                    end else begin
                        busy_d    = 1'b1;
                        busrq_n_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (!bus.busak_n) begin
                    bus_own_d = 1'b1;
                    s_ready_d = 1'b1;
                    state_d   = LOAD;
                end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                    busrq_n_d = 1'b1;
                    err_d     = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LOAD: begin
                if (bus.s_valid) begin
                    mem_a_d      = addr_q;
                    mem_do_d     = bus.s_data;
                    mem_mreq_n_d = 1'b0;
                    mem_wr_n_d   = 1'b0;
                    s_ready_d    = 1'b0;
                    state_d      = STROBE;
                end
            end
            STROBE: begin
                mem_mreq_n_d = 1'b1;
                mem_wr_n_d   = 1'b1;
                addr_d       = addr_q + 16'd1;
                rem_d        = rem_q - 16'd1;
                if (rem_q == 16'd1) begin
                    busrq_n_d = 1'b1;
                    bus_own_d = 1'b0;
                    state_d   = REL;
                end else begin
                    s_ready_d = 1'b1;
                    state_d   = LOAD;
                end
            end
            REL: begin
                // Only report completion once the CPU has actually taken the bus back.
                if (bus.busak_n) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (lost) begin
            mem_mreq_n_d = 1'b1;
            mem_wr_n_d   = 1'b1;
            bus_own_d    = 1'b0;
            busrq_n_d    = 1'b1;
            s_ready_d    = 1'b0;
            err_d        = 1'b1;
            busy_d       = 1'b0;
            state_d      = IDLE;
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.busrq_n    = busrq_n_q;
    assign bus.bus_own    = bus_own_q;
    assign bus.mem_a      = mem_a_q;
    assign bus.mem_do     = mem_do_q;
    assign bus.mem_mreq_n = mem_mreq_n_q;
    assign bus.mem_wr_n   = mem_wr_n_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule
